// File: rtl/alu_seq.sv
// Multi-cycle ALU: one-cycle logic/compare ops plus iterative shift-add multiply
// and restoring divide, with valid/ready handshakes on both sides.
module alu_seq #(
  parameter int BIT_WIDTH  = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int MUL_ENABLE = 1,
  parameter int DIV_ENABLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           alu_fn,
  input  logic [BIT_WIDTH-1:0] in1,
  input  logic [BIT_WIDTH-1:0] in2,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 div_by_zero,
  output logic                 busy
);

  localparam int W  = BIT_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  state_t state, state_next;

  logic [4:0]           fn_r;
  logic [2*W-1:0]       a_reg, acc;
  logic [W-1:0]         b_reg;
  logic [CW-1:0]        cnt;
  logic                 neg_q, neg_r;
  logic [W-1:0]         out_r;
  logic [TAG_WIDTH-1:0] tag_r;
  logic                 dbz_r;

  logic           is_mul_in, is_div_in, sgn_in, zero_div, lt, eq;
  logic [W-1:0]   abs_a, abs_b, single_res, iter_res;
  logic [2*W-1:0] a_step, acc_step, prod;
  logic [W-1:0]   b_step, quot, rem;
  logic [W:0]     r_shift, diff;

  assign is_mul_in = (MUL_ENABLE != 0) && (alu_fn == 5'h10 || alu_fn == 5'h11);
  assign is_div_in = (DIV_ENABLE != 0) && (alu_fn >= 5'h12 && alu_fn <= 5'h15);
  assign sgn_in    = is_mul_in || (is_div_in && !alu_fn[2]);
  assign zero_div  = (in2 == '0);
  assign abs_a     = (sgn_in && in1[W-1]) ? -in1 : in1;
  assign abs_b     = (sgn_in && in2[W-1]) ? -in2 : in2;
  assign lt        = $signed(in1) < $signed(in2);
  assign eq        = (in1 == in2);

  always_comb begin
    single_res = '0;
    case (alu_fn)
      5'h00: single_res = in1 + in2;
      5'h01: single_res = in1 - in2;
      5'h02: single_res = in1 & in2;
      5'h03: single_res = in1 | in2;
      5'h04: single_res = in1 ^ in2;
      5'h05: single_res = ~(in1 & in2);
      5'h06: single_res = ~(in1 | in2);
      5'h07: single_res = ~(in1 ^ in2);
      5'h09: single_res = {{(W-1){1'b0}}, eq};
      5'h0A: single_res = {{(W-1){1'b0}}, lt};
      5'h0B: single_res = {{(W-1){1'b0}}, lt | eq};
      5'h0C: single_res = {{(W-1){1'b0}}, 1'b1};
      5'h0D: single_res = {{(W-1){1'b0}}, !eq};
      5'h0E: single_res = {{(W-1){1'b0}}, !lt};
      5'h0F: single_res = {{(W-1){1'b0}}, !lt && !eq};
      default: single_res = '0;
    endcase
    // Divide by zero finishes immediately: quotient all ones, remainder = dividend.
    if (is_div_in && zero_div)
      single_res = alu_fn[0] ? in1 : '1;
  end

  // One iteration step. Multiply: a_reg is the shifting multiplicand, b_reg the
  // multiplier. Divide: a_reg low half is the divisor, b_reg shifts dividend bits
  // out and quotient bits in, acc holds the partial remainder.
  always_comb begin
    a_step   = a_reg;
    b_step   = b_reg;
    acc_step = acc;
    r_shift  = {acc[W-1:0], b_reg[W-1]};
    diff     = r_shift - {1'b0, a_reg[W-1:0]};
    if (fn_r[4:1] == 4'b1000) begin
      acc_step = acc + (b_reg[0] ? a_reg : '0);
      a_step   = a_reg << 1;
      b_step   = b_reg >> 1;
    end else begin
      b_step   = {b_reg[W-2:0], !diff[W]};
      acc_step = {{(W-1){1'b0}}, diff[W] ? r_shift : diff};
    end
    prod = neg_q ? -acc_step : acc_step;
    quot = b_step;
    rem  = acc_step[W-1:0];
    if (fn_r[4:1] == 4'b1000)
      iter_res = fn_r[0] ? prod[2*W-1:W] : prod[W-1:0];
    else
      iter_res = fn_r[0] ? (neg_r ? -rem : rem) : (neg_q ? -quot : quot);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid)
              state_next = (is_mul_in || (is_div_in && !zero_div)) ? ITER : DONE;
      ITER: if (cnt == LAST) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      fn_r  <= '0;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      out_r <= '0;
      tag_r <= '0;
      dbz_r <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (in_valid) begin
          fn_r  <= alu_fn;
          tag_r <= in_tag;
          cnt   <= '0;
          acc   <= '0;
          a_reg <= {{W{1'b0}}, is_mul_in ? abs_a : abs_b};
          b_reg <= is_mul_in ? abs_b : abs_a;
          neg_q <= sgn_in && (in1[W-1] ^ in2[W-1]);
          neg_r <= sgn_in && in1[W-1];
          out_r <= single_res;
          dbz_r <= is_div_in && zero_div;
        end
        ITER: begin
          a_reg <= a_step;
          b_reg <= b_step;
          acc   <= acc_step;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) out_r <= iter_res;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign out         = out_r;
  assign out_tag     = tag_r;
  assign div_by_zero = dbz_r;

endmodule
